// File: rtl/riscv_register_file_tag_ctx.sv
// rtl/riscv_register_file_tag_ctx.sv - DIFT tag register file with clear/dump/load sweep engine
module riscv_register_file_tag_ctx #(
    parameter int ADDR_WIDTH   = 5,
    parameter int TAG_WIDTH    = 1,
    parameter int WRITE_BYPASS = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    input  logic [ADDR_WIDTH-1:0] raddr_c_i,
    output logic [TAG_WIDTH-1:0]  rdata_a_o,
    output logic [TAG_WIDTH-1:0]  rdata_b_o,
    output logic [TAG_WIDTH-1:0]  rdata_c_o,
    input  logic [ADDR_WIDTH-1:0] waddr_a_i,
    input  logic [ADDR_WIDTH-1:0] waddr_b_i,
    input  logic [TAG_WIDTH-1:0]  wdata_a_i,
    input  logic [TAG_WIDTH-1:0]  wdata_b_i,
    input  logic                  we_a_i,
    input  logic                  we_b_i,
    input  logic                  clear_i,
    input  logic                  dump_req_i,
    input  logic                  load_req_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  dump_valid_o,
    input  logic                  dump_ready_i,
    output logic [ADDR_WIDTH-1:0] dump_addr_o,
    output logic [TAG_WIDTH-1:0]  dump_tag_o,
    input  logic                  load_valid_i,
    output logic                  load_ready_o,
    input  logic [TAG_WIDTH-1:0]  load_tag_i,
    output logic                  any_tag_o
);
    localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, DUMP, LOAD} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [TAG_WIDTH-1:0]  mem_q [NUM_WORDS];
    logic                  done_q, any_tag_q, any_or;
    logic                  idle, do_clear, we_a_eff, we_b_eff, dump_hs, load_hs, last_beat;
    logic [ADDR_WIDTH-1:0] raddr [3];
    logic [TAG_WIDTH-1:0]  rdata [3];

    assign idle      = (state_q == IDLE);
    assign do_clear  = idle & clear_i;
    // Port writes only land in IDLE, lose to a clear, and never touch x0.
    assign we_a_eff  = idle & ~clear_i & we_a_i & (waddr_a_i != '0);
    assign we_b_eff  = idle & ~clear_i & we_b_i & (waddr_b_i != '0);
    assign dump_hs   = (state_q == DUMP) & dump_ready_i;
    assign load_hs   = (state_q == LOAD) & load_valid_i;
    assign last_beat = (idx_q == LAST_IDX);

    assign raddr[0]  = raddr_a_i;
    assign raddr[1]  = raddr_b_i;
    assign raddr[2]  = raddr_c_i;
    assign rdata_a_o = rdata[0];
    assign rdata_b_o = rdata[1];
    assign rdata_c_o = rdata[2];

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            rdata[r] = (raddr[r] == '0) ? '0 : mem_q[raddr[r]];
            if (WRITE_BYPASS != 0) begin
                if (we_a_eff && (waddr_a_i == raddr[r])) rdata[r] = wdata_a_i;
                if (we_b_eff && (waddr_b_i == raddr[r])) rdata[r] = wdata_b_i;
            end
        end
    end

    always_comb begin
        any_or = 1'b0;
        for (int i = 0; i < NUM_WORDS; i++) any_or = any_or | (|mem_q[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clear_i)         state_d = IDLE;
                else if (dump_req_i) state_d = DUMP;
                else if (load_req_i) state_d = LOAD;
            end
            DUMP:    if (dump_hs && last_beat) state_d = IDLE;
            LOAD:    if (load_hs && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o       = ~idle;
        dump_valid_o = 1'b0;
        dump_addr_o  = '0;
        dump_tag_o   = '0;
        load_ready_o = 1'b0;
        case (state_q)
            DUMP: begin
                dump_valid_o = 1'b1;
                dump_addr_o  = idx_q;
                dump_tag_o   = mem_q[idx_q];
            end
            LOAD:    load_ready_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= FIRST_IDX;
            done_q    <= 1'b0;
            any_tag_q <= 1'b0;
        end else begin
            done_q    <= do_clear | ((dump_hs | load_hs) & last_beat);
            any_tag_q <= any_or;
            if (dump_hs || load_hs) idx_q <= last_beat ? FIRST_IDX : idx_q + ADDR_WIDTH'(1);
        end
    end

    // Port B is written after port A so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (rst || do_clear) begin
            for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
        end else begin
            if (we_a_eff) mem_q[waddr_a_i] <= wdata_a_i;
            if (we_b_eff) mem_q[waddr_b_i] <= wdata_b_i;
            if (load_hs)  mem_q[idx_q]     <= load_tag_i;
        end
    end

    assign done_o    = done_q;
    assign any_tag_o = any_tag_q;
endmodule

// File: tb/tb_riscv_register_file_tag_ctx.sv
// tb/tb_riscv_register_file_tag_ctx.sv - scoreboard bench for riscv_register_file_tag_ctx
module tb_riscv_register_file_tag_ctx;
    localparam int AW = 5;
    localparam int TW = 2;
    localparam int NW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] raddr_a, raddr_b, raddr_c, waddr_a, waddr_b;
    logic [TW-1:0] wdata_a, wdata_b, load_tag;
    logic          we_a, we_b, clear, dump_req, load_req, dump_ready, load_valid;

    logic [TW-1:0] rd_a_b, rd_b_b, rd_c_b, dump_tag_b;
    logic [AW-1:0] dump_addr_b;
    logic          busy_b, done_b, dump_valid_b, load_ready_b, any_tag_b;
    logic [TW-1:0] rd_a_n, rd_b_n, rd_c_n, dump_tag_n;
    logic [AW-1:0] dump_addr_n;
    logic          busy_n, done_n, dump_valid_n, load_ready_n, any_tag_n;

    riscv_register_file_tag_ctx #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW), .WRITE_BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst),
        .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .raddr_c_i(raddr_c),
        .rdata_a_o(rd_a_b), .rdata_b_o(rd_b_b), .rdata_c_o(rd_c_b),
        .waddr_a_i(waddr_a), .waddr_b_i(waddr_b), .wdata_a_i(wdata_a), .wdata_b_i(wdata_b),
        .we_a_i(we_a), .we_b_i(we_b), .clear_i(clear), .dump_req_i(dump_req), .load_req_i(load_req),
        .busy_o(busy_b), .done_o(done_b), .dump_valid_o(dump_valid_b), .dump_ready_i(dump_ready),
        .dump_addr_o(dump_addr_b), .dump_tag_o(dump_tag_b), .load_valid_i(load_valid),
        .load_ready_o(load_ready_b), .load_tag_i(load_tag), .any_tag_o(any_tag_b)
    );

    riscv_register_file_tag_ctx #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW), .WRITE_BYPASS(0)) dut_nob (
        .clk(clk), .rst(rst),
        .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .raddr_c_i(raddr_c),
        .rdata_a_o(rd_a_n), .rdata_b_o(rd_b_n), .rdata_c_o(rd_c_n),
        .waddr_a_i(waddr_a), .waddr_b_i(waddr_b), .wdata_a_i(wdata_a), .wdata_b_i(wdata_b),
        .we_a_i(we_a), .we_b_i(we_b), .clear_i(clear), .dump_req_i(dump_req), .load_req_i(load_req),
        .busy_o(busy_n), .done_o(done_n), .dump_valid_o(dump_valid_n), .dump_ready_i(dump_ready),
        .dump_addr_o(dump_addr_n), .dump_tag_o(dump_tag_n), .load_valid_i(load_valid),
        .load_ready_o(load_ready_n), .load_tag_i(load_tag), .any_tag_o(any_tag_n)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    logic [TW-1:0] mdl [NW];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < NW; i++) begin
            @(negedge clk);
            raddr_a = AW'(i);
            #1;
            check(tag, rd_a_b, mdl[i]);
            check(tag, rd_a_n, mdl[i]);
        end
    endtask

    task automatic preload(input int bias);
        exp_q.delete();
        for (int i = 1; i < NW; i++) begin
            next_cycle();
            we_a = 1'b1; waddr_a = AW'(i); wdata_a = TW'((i + bias) % 4);
            mdl[i] = TW'((i + bias) % 4);
            exp_q.push_back(i * 256 + (i + bias) % 4);
        end
        next_cycle();
        we_a = 1'b0;
    endtask

    task automatic check_beat(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_extra_beat"}, 32'd1, 32'd0);
        end else begin
            check({tag, "_addr"}, dump_addr_b, exp_q[0] >> 8);
            check({tag, "_tag"},  dump_tag_b,  exp_q[0] & 255);
        end
    endtask

    int beats, dones, cycles;

    initial begin
        rst = 1'b1; raddr_a = '0; raddr_b = '0; raddr_c = '0; waddr_a = '0; waddr_b = '0;
        wdata_a = '0; wdata_b = '0; load_tag = '0; we_a = 1'b0; we_b = 1'b0; clear = 1'b0;
        dump_req = 1'b0; load_req = 1'b0; dump_ready = 1'b0; load_valid = 1'b0;
        for (int i = 0; i < NW; i++) mdl[i] = '0;
        repeat (3) next_cycle();
        rst = 1'b0;
        raddr_a = AW'(5);
        @(negedge clk);
        check("rst_busy", busy_b, 0);
        check("rst_done", done_b, 0);
        check("rst_dump_valid", dump_valid_b, 0);
        check("rst_load_ready", load_ready_b, 0);
        check("rst_any_tag", any_tag_b, 0);
        check("rst_rdata", rd_a_b, 0);

        // x5 <= 3 on port A, x0 <= 3 on port B (dropped)
        next_cycle();
        we_a = 1'b1; waddr_a = AW'(5); wdata_a = 2'h3;
        we_b = 1'b1; waddr_b = '0;     wdata_b = 2'h3;
        next_cycle();
        we_a = 1'b0; we_b = 1'b0; raddr_a = AW'(5); raddr_b = '0;
        mdl[5] = 2'h3;
        @(negedge clk);
        check("wr_x5", rd_a_b, 3);
        check("wr_x5_nob", rd_a_n, 3);
        check("wr_x0", rd_b_b, 0);
        next_cycle();
        @(negedge clk);
        check("any_tag_after_wr", any_tag_b, 1);

        // same-cycle collision on x7, B wins; bypass only on dut_byp
        next_cycle();
        we_a = 1'b1; waddr_a = AW'(7); wdata_a = 2'h1;
        we_b = 1'b1; waddr_b = AW'(7); wdata_b = 2'h2;
        raddr_c = AW'(7);
        @(negedge clk);
        check("bypass_b_wins", rd_c_b, 2);
        check("nobypass_old", rd_c_n, 0);
        next_cycle();
        we_a = 1'b0; we_b = 1'b0;
        mdl[7] = 2'h2;
        @(negedge clk);
        check("collide_x7", rd_c_b, 2);
        check("collide_x7_nob", rd_c_n, 2);

        // dump with random back-pressure
        preload(0);
        dump_req = 1'b1;
        next_cycle();
        dump_req = 1'b0;
        beats = 0; dones = 0; cycles = 0;
        while (cycles < 2000 && dones == 0) begin
            dump_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done_b) begin
                dones++;
            end else begin
                check("dump_busy", busy_b, 1);
                check("dump_valid", dump_valid_b, 1);
                check_beat("dump");
                if (dump_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
            next_cycle();
            cycles++;
        end
        dump_ready = 1'b0;
        check("dump_beats", beats, NW - 1);
        check("dump_done_seen", dones, 1);
        @(negedge clk);
        check("dump_done_pulse", done_b, 0);
        check("dump_idle_busy", busy_b, 0);
        check("dump_idle_valid", dump_valid_b, 0);
        check("dump_idle_addr", dump_addr_b, 0);
        read_all("dump_unchanged");

        // load 0x2 everywhere with gaps; port-A writes during LOAD are ignored
        next_cycle();
        load_req = 1'b1;
        next_cycle();
        load_req = 1'b0;
        beats = 0; dones = 0; cycles = 0;
        while (cycles < 2000 && dones == 0) begin
            load_valid = (beats < NW - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            load_tag = 2'h2;
            we_a = (beats < NW - 1); waddr_a = AW'(9); wdata_a = 2'h1;
            @(negedge clk);
            if (done_b) begin
                dones++;
            end else begin
                check("load_ready", load_ready_b, 1);
                check("load_busy", busy_b, 1);
                if (load_valid) beats++;
            end
            next_cycle();
            cycles++;
        end
        we_a = 1'b0; load_valid = 1'b0;
        check("load_beats", beats, NW - 1);
        check("load_done_seen", dones, 1);
        for (int i = 1; i < NW; i++) mdl[i] = 2'h2;
        @(negedge clk);
        check("load_idle_ready", load_ready_b, 0);
        read_all("load_data");

        // clear overrides a same-cycle write
        next_cycle();
        clear = 1'b1; we_a = 1'b1; waddr_a = AW'(3); wdata_a = 2'h1;
        next_cycle();
        clear = 1'b0; we_a = 1'b0;
        for (int i = 0; i < NW; i++) mdl[i] = '0;
        @(negedge clk);
        check("clear_done", done_b, 1);
        check("clear_busy", busy_b, 0);
        next_cycle();
        @(negedge clk);
        check("clear_any_tag", any_tag_b, 0);
        check("clear_done_once", done_b, 0);
        read_all("clear_data");

        // clear beats dump_req
        next_cycle();
        we_a = 1'b1; waddr_a = AW'(4); wdata_a = 2'h1;
        next_cycle();
        we_a = 1'b0; clear = 1'b1; dump_req = 1'b1; dump_ready = 1'b1;
        next_cycle();
        clear = 1'b0; dump_req = 1'b0;
        @(negedge clk);
        check("clr_dump_done", done_b, 1);
        for (int k = 0; k < 3; k++) begin
            check("clr_dump_busy", busy_b, 0);
            check("clr_dump_valid", dump_valid_b, 0);
            next_cycle();
            @(negedge clk);
        end
        dump_ready = 1'b0;
        read_all("clr_dump_data");

        // reset aborts a dump after beat 10
        preload(1);
        dump_req = 1'b1;
        next_cycle();
        dump_req = 1'b0; dump_ready = 1'b1;
        beats = 0; cycles = 0;
        while (beats < 10 && cycles < 200) begin
            @(negedge clk);
            check("abort_valid", dump_valid_b, 1);
            check_beat("abort");
            if (dump_valid_b && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                beats++;
            end
            next_cycle();
            cycles++;
        end
        check("abort_beats", beats, 10);
        rst = 1'b1; dump_ready = 1'b0;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < NW; i++) mdl[i] = '0;
        @(negedge clk);
        check("abort_busy", busy_b, 0);
        check("abort_dump_valid", dump_valid_b, 0);
        check("abort_done", done_b, 0);
        next_cycle();
        @(negedge clk);
        check("abort_done_late", done_b, 0);
        read_all("abort_data");

        next_cycle();
        exp_q.delete();
        exp_q.push_back(1 * 256 + 0);
        dump_req = 1'b1;
        next_cycle();
        dump_req = 1'b0;
        @(negedge clk);
        check("restart_valid", dump_valid_b, 1);
        check_beat("restart");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/riscv_register_file_tag_ctx.md
Name: riscv_register_file_tag_ctx

Overview:
Flip-flop DIFT tag register file for the RI5CY core, parametrised in address and tag width, with an optional write-to-read bypass.
It holds one TAG_WIDTH-bit tag per GPR; tag 0 is hard-wired to zero.
A sweep engine provides one-cycle bulk clear plus streamed dump and load of all tags over valid/ready channels, used for context switch and checkpoint by the tag-policy unit.
It sits beside the GPR file in the ID stage.

Parameters:
ADDR_WIDTH, 5, register address width; NUM_WORDS = 2**ADDR_WIDTH.
TAG_WIDTH, 1, bits per tag (legal 1..8).
WRITE_BYPASS, 0, if 1 a read returns the tag being written in the same cycle.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
raddr_a_i / raddr_b_i / raddr_c_i  in  ADDR_WIDTH  read addresses
rdata_a_o / rdata_b_o / rdata_c_o  out  TAG_WIDTH  read tags (combinational)
waddr_a_i, waddr_b_i  in  ADDR_WIDTH  write addresses
wdata_a_i, wdata_b_i  in  TAG_WIDTH  write tags
we_a_i, we_b_i  in  1  write enables
clear_i  in  1  bulk-clear request
dump_req_i  in  1  start dump sweep
load_req_i  in  1  start load sweep
busy_o  out  1  engine not IDLE
done_o  out  1  one-cycle pulse at sweep end
dump_valid_o  out  1  dump beat valid
dump_ready_i  in  1  dump consumer ready
dump_addr_o  out  ADDR_WIDTH  register index of the dump beat
dump_tag_o  out  TAG_WIDTH  tag of the dump beat
load_valid_i  in  1  load beat valid
load_ready_o  out  1  load beat accepted
load_tag_i  in  TAG_WIDTH  tag to load
any_tag_o  out  1  registered OR-reduce of all tag bits

Behaviour:
- Reset: all tags 0, FSM=IDLE, idx=1; busy_o, done_o, dump_valid_o, load_ready_o and any_tag_o are 0.
- Reads: rdata = mem[raddr]; address 0 always reads 0.
  - With WRITE_BYPASS=1: if an enabled port writes the read address in this cycle, rdata returns that write tag; port B wins over port A. Address 0 is never bypassed.
- Writes (IDLE only): take effect at the posedge; visible on the next cycle without bypass.
  - Writes to address 0 are dropped.
  - If both ports write the same address, B wins.
  - we_a_i/we_b_i are ignored while busy_o=1; the core stalls on busy_o.
- FSM states are IDLE, DUMP and LOAD. Requests are sampled only in IDLE, with priority clear_i > dump_req_i > load_req_i. Requests outside IDLE are ignored.
- Clear: in IDLE with clear_i=1, all tags are 0 at the next edge and override any same-cycle write. The FSM stays in IDLE and done_o pulses in the next cycle.
- DUMP:
  - Entered with idx=1.
  - dump_valid_o=1, dump_addr_o=idx, dump_tag_o=mem[idx]; outputs held stable until dump_ready_i.
  - On each handshake idx increments.
  - Handshake at idx=NUM_WORDS-1 → IDLE, idx=1, done_o=1 for one cycle.
  - Exactly NUM_WORDS-1 beats. The tag contents are unchanged.
- LOAD:
  - Entered with idx=1; load_ready_o=1.
  - On load_valid_i=1, mem[idx] <= load_tag_i and idx increments.
  - The final beat at idx=NUM_WORDS-1 → IDLE and done_o pulses. Beats with load_valid_i=0 are waits.
- Outside DUMP, dump_valid_o=0 and dump_addr_o/dump_tag_o are 0. Outside LOAD, load_ready_o=0.
- any_tag_o: registered, updated every cycle from the post-update tag state. It lags the tag state by one cycle; after a clear it is 0 one cycle later.
- rst asserted mid-sweep aborts immediately: IDLE, tags 0, no done_o pulse.
- Width rules: idx is ADDR_WIDTH bits and never wraps to 0 inside a sweep. Tags are stored at full TAG_WIDTH with no truncation.

Test Plan:
- Reset sequence; write A x5=0x3 (TAG_WIDTH=2), read x5 next cycle → 0x3; write to x0 then read x0 → 0; any_tag_o=1 two cycles after the write.
- Same cycle we_a (x7=1), we_b (x7=2) → x7=2. With WRITE_BYPASS=1, a same-cycle read of x7 returns 2; with WRITE_BYPASS=0 it returns the old value.
- Preload x1..x31 = idx[1:0]; dump_req with dump_ready_i toggling randomly → 31 beats in order with addr 1..31 and correct tags, data held while stalled, done_o once, busy_o high throughout.
- load_req with 31 beats of 0x2 and gaps in load_valid_i → all x1..x31 read 0x2 after done_o; x0 reads 0; we_a_i asserted during LOAD is ignored.
- clear_i and we_a_i (x3=1) in the same cycle → x3=0 and all tags 0; any_tag_o=0 one cycle later. clear_i and dump_req_i together → clear only, no dump beats.
- rst asserted at beat 10 of a dump → next cycle IDLE, dump_valid_o=0, all tags 0, no done_o; a new dump then starts at addr 1.
